// File: rtl/prio_latch_seg.sv
// prio_latch_seg: synchronised priority encoder with quiz-buzzer lockout
// driving a two-digit multiplexed common-anode seven-segment display.
module prio_latch_seg #(
    parameter int N        = 8,
    parameter int SCAN_DIV = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    input  logic         mode,
    input  logic         clr,
    output logic         valid,
    output logic [3:0]   idx,
    output logic [6:0]   seg,
    output logic [1:0]   dig
);
    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state;
    logic [N-1:0]  sync1, sync2;
    logic          mode_q;
    logic [3:0]    win;
    logic          any;
    logic [CW-1:0] cnt;
    logic          wrap;
    logic [1:0]    dig_next;
    logic [3:0]    digit_val;
    logic [6:0]    seg_next;

    function automatic logic [6:0] pat(input logic [3:0] d);
        case (d)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
    endfunction

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        win = '0;
        for (int i = 0; i < N; i++)
            if (sync2[i]) win = 4'(i);
    end

    assign any       = |sync2;
    assign wrap      = cnt == CW'(SCAN_DIV - 1);
    assign dig_next  = wrap ? ~dig : dig;
    assign digit_val = dig_next[0] ? ((idx >= 4'd10) ? 4'd1 : 4'd0)
                                   : ((idx >= 4'd10) ? idx - 4'd10 : idx);
    assign seg_next  = (!valid || (dig_next[0] && idx < 4'd10)) ? 7'b1111111 : pat(digit_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mode_q <= 1'b0;
            valid  <= 1'b0;
            idx    <= '0;
        end else begin
            mode_q <= mode;
            if (!mode) begin
                state <= IDLE;
                valid <= any;
                idx   <= win;
            end else if (!mode_q) begin
                state <= IDLE;
                valid <= 1'b0;
                idx   <= '0;
            end else if (state == LOCKED) begin
                if (clr) begin
                    state <= IDLE;
                    valid <= 1'b0;
                    idx   <= '0;
                end
            end else if (any) begin
                state <= LOCKED;
                valid <= 1'b1;
                idx   <= win;
            end else begin
                valid <= 1'b0;
                idx   <= '0;
            end
        end
    end

    // seg is computed for the digit that becomes active on this edge, so the two stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dig <= 2'b10;
            seg <= 7'b1111111;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            dig <= dig_next;
            seg <= seg_next;
        end
    end
endmodule
